// File: rtl/merge_tree_scheduler.sv
// Collects one RIDS from every lookup source and launches them into a fixed-latency merge tree.
// Results are captured in a small FWFT FIFO; a credit counter bounds in-flight merges to FIFO room.
module merge_tree_scheduler #(
    parameter int NUM_RIDS      = 5,
    parameter int RIDS_WIDTH    = 32,
    parameter int MERGE_LATENCY = 12,
    parameter int FIFO_DEPTH    = 4,
    parameter int TAG_WIDTH     = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_RIDS-1:0]            in_valid,
    output logic [NUM_RIDS-1:0]            in_ready,
    input  logic [NUM_RIDS*RIDS_WIDTH-1:0] in_rids,
    output logic [NUM_RIDS*RIDS_WIDTH-1:0] tree_in,
    input  logic [RIDS_WIDTH-1:0]          tree_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [RIDS_WIDTH-1:0]          out_rids,
    output logic [TAG_WIDTH-1:0]           out_tag,
    output logic                           busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, STALL, DRAIN} state_t;

    state_t                           state;
    logic [NUM_RIDS-1:0]              held;
    logic [NUM_RIDS-1:0]              held_nxt;
    logic [NUM_RIDS-1:0]              xfer;
    logic [NUM_RIDS*RIDS_WIDTH-1:0]   hold_regs;
    logic [CRED_W-1:0]                credits;
    logic [CRED_W-1:0]                credits_nxt;
    logic [TAG_WIDTH-1:0]             tag_cnt;
    logic [MERGE_LATENCY-1:0]         pipe_valid;
    logic [MERGE_LATENCY-1:0]         pipe_valid_nxt;
    logic [TAG_WIDTH-1:0]             pipe_tag [MERGE_LATENCY];
    logic [RIDS_WIDTH-1:0]            fifo_rids [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]             fifo_tag [FIFO_DEPTH];
    logic [PTR_W:0]                   wr_ptr;
    logic [PTR_W:0]                   rd_ptr;
    logic [PTR_W:0]                   count;
    logic [PTR_W:0]                   count_nxt;
    logic                             issue;
    logic                             push;
    logic                             pop;
    logic                             fifo_full;

    // A source may refill its slot in the same cycle the current operand set launches.
    assign issue     = (&held) && (credits != '0);
    assign in_ready  = ~held | {NUM_RIDS{issue}};
    assign xfer      = in_valid & in_ready;
    assign held_nxt  = xfer | (held & ~{NUM_RIDS{issue}});
    assign tree_in   = hold_regs;

    assign push      = pipe_valid[MERGE_LATENCY-1];
    assign pop       = out_valid && out_ready;
    assign count     = wr_ptr - rd_ptr;
    assign out_valid = (count != '0);
    assign fifo_full = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign out_rids  = fifo_rids[rd_ptr[PTR_W-1:0]];
    assign out_tag   = fifo_tag[rd_ptr[PTR_W-1:0]];
    assign busy      = (state != IDLE);

    assign pipe_valid_nxt = (pipe_valid << 1) | MERGE_LATENCY'(issue);
    assign count_nxt      = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

    always_comb begin
        credits_nxt = credits;
        if (issue && !pop) begin
            credits_nxt = credits - CRED_W'(1);
        end else if (pop && !issue) begin
            credits_nxt = credits + CRED_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RIDS; i++) begin
            if (xfer[i]) begin
                hold_regs[i*RIDS_WIDTH +: RIDS_WIDTH] <= in_rids[i*RIDS_WIDTH +: RIDS_WIDTH];
            end
        end
        pipe_tag[0] <= tag_cnt;
        for (int k = 1; k < MERGE_LATENCY; k++) begin
            pipe_tag[k] <= pipe_tag[k-1];
        end
        if (push) begin
            fifo_rids[wr_ptr[PTR_W-1:0]] <= tree_out;
            fifo_tag[wr_ptr[PTR_W-1:0]]  <= pipe_tag[MERGE_LATENCY-1];
        end
    end

    // Clearing the valid pipe on reset is what makes late tree_out values harmless.
    always_ff @(posedge clk) begin
        if (!reset) begin
            held       <= '0;
            credits    <= CRED_W'(FIFO_DEPTH);
            tag_cnt    <= '0;
            pipe_valid <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            held       <= held_nxt;
            credits    <= credits_nxt;
            pipe_valid <= pipe_valid_nxt;
            if (issue) begin
                tag_cnt <= tag_cnt + TAG_WIDTH'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else if (held_nxt == '0) begin
            state <= ((|pipe_valid_nxt) || (count_nxt != '0)) ? DRAIN : IDLE;
        end else if ((&held_nxt) && (credits_nxt == '0)) begin
            state <= STALL;
        end else begin
            state <= COLLECT;
        end
    end

    assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full));

endmodule

// File: tb/tb_merge_tree_scheduler.sv
// Directed bench for merge_tree_scheduler: per-source drivers, a merge-tree model and a
// scoreboard queue of expected results popped by an independent output monitor.
module tb_merge_tree_scheduler;

    localparam int NUM   = 5;
    localparam int RW    = 32;
    localparam int LAT   = 12;
    localparam int DEPTH = 4;
    localparam int TW    = 4;
    localparam int MAXS  = 64;

    typedef struct {
        logic [RW-1:0] rids;
        logic [TW-1:0] tag;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM-1:0]       in_valid;
    logic [NUM-1:0]       in_ready;
    logic [NUM*RW-1:0]    in_rids;
    logic [NUM*RW-1:0]    tree_in;
    logic [RW-1:0]        tree_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [RW-1:0]        out_rids;
    logic [TW-1:0]        out_tag;
    logic                 busy;

    int                   checks = 0;
    int                   passes = 0;
    int                   cyc = 0;
    int                   nsets = 0;
    int                   ptr [NUM];
    logic [RW-1:0]        set_rids [MAXS][NUM];
    int                   set_start [MAXS][NUM];
    logic [TW-1:0]        tag_model = '0;
    exp_t                 sb [$];
    logic [RW-1:0]        tree_pipe [LAT];

    merge_tree_scheduler #(
        .NUM_RIDS(NUM), .RIDS_WIDTH(RW), .MERGE_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_rids(in_rids),
        .tree_in(tree_in), .tree_out(tree_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rids(out_rids), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Position-dependent rotation so swapped source slices change the result.
    function automatic logic [RW-1:0] merge_fn(input logic [NUM*RW-1:0] bus);
        logic [RW-1:0] r;
        logic [RW-1:0] s;
        r = '0;
        for (int i = 0; i < NUM; i++) begin
            s = bus[i*RW +: RW];
            if (i == 0) r = r ^ s;
            else        r = r ^ ((s << (4*i)) | (s >> (RW - 4*i)));
        end
        return r;
    endfunction

    always @(posedge clk) begin
        tree_pipe[0] <= merge_fn(tree_in);
        for (int k = 1; k < LAT; k++) tree_pipe[k] <= tree_pipe[k-1];
    end
    assign tree_out = tree_pipe[LAT-1];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    endtask

    task automatic applyStimulus(input logic [RW-1:0] base, input int start, input int stride);
        logic [NUM*RW-1:0] bus;
        exp_t e;
        for (int i = 0; i < NUM; i++) begin
            set_rids[nsets][i]  = base + RW'(i) * 32'h0111_1111;
            set_start[nsets][i] = start + stride * i;
            bus[i*RW +: RW]     = set_rids[nsets][i];
        end
        e.rids = merge_fn(bus);
        e.tag  = tag_model;
        sb.push_back(e);
        tag_model = tag_model + TW'(1);
        nsets++;
    endtask

    task automatic waitIdle(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 2000 && !done; n++) begin
            @(negedge clk);
            if (!busy && ptr[0] == nsets) done = 1'b1;
        end
        if (!done) checkOutput(name, busy, 0);
    endtask

    // Per-source driver: each source advances independently on its own handshake.
    initial begin
        logic [NUM-1:0] took;
        for (int i = 0; i < NUM; i++) ptr[i] = 0;
        in_valid = '0;
        in_rids  = '0;
        forever begin
            @(negedge clk);
            took = in_valid & in_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM; i++) begin
                if (took[i]) ptr[i]++;
                if (ptr[i] < nsets && cyc >= set_start[ptr[i]][i]) begin
                    in_valid[i]         = 1'b1;
                    in_rids[i*RW +: RW] = set_rids[ptr[i]][i];
                end else begin
                    in_valid[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", out_valid, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("out_rids", out_rids, e.rids);
                checkOutput("out_tag", out_tag, e.tag);
            end
        end
    end

    initial begin
        int k;
        int seen;
        logic [NUM-1:0] hm;
        logic [NUM-1:0] exp_ready;
        bit got;

        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 5'h1f);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_credits", dut.credits, DEPTH);

        $display("[TB] single merge");
        @(posedge clk); #1;
        k = cyc;
        applyStimulus(32'h1234_5678, k + 1, 0);
        got  = 1'b0;
        seen = 0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (out_valid) begin
                got  = 1'b1;
                seen = cyc;
            end
        end
        checkOutput("single_latency", seen, k + 3 + LAT);
        waitIdle("single_idle_timeout");

        $display("[TB] staggered sources");
        @(posedge clk); #1;
        k = cyc;
        applyStimulus(32'hA5A5_0F0F, k + 1, 2);
        for (int n = 0; n <= 10; n++) begin
            @(negedge clk);
            hm = '0;
            for (int j = 0; j < NUM; j++) if (k + 1 + 2*j <= cyc - 1) hm[j] = 1'b1;
            exp_ready = (&hm) ? 5'h1f : ~hm;
            checkOutput("stagger_in_ready", in_ready, exp_ready);
        end
        waitIdle("stagger_idle_timeout");

        $display("[TB] backpressure");
        @(posedge clk); #1;
        out_ready = 1'b0;
        k = cyc;
        for (int s = 0; s < 6; s++) applyStimulus(32'h1000_0001 * (s + 1), k + 1, 0);
        repeat (30) @(negedge clk);
        checkOutput("stall_in_ready", in_ready, 0);
        checkOutput("stall_out_valid", out_valid, 1);
        checkOutput("stall_credits", dut.credits, 0);
        checkOutput("stall_pending_sets", nsets - ptr[0], 1);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        checkOutput("pop_reissue_ready", in_ready, 5'h1f);
        @(negedge clk);
        checkOutput("pop_restall_ready", in_ready, 0);
        checkOutput("pop_pending_sets", nsets - ptr[0], 0);
        @(posedge clk); #1 out_ready = 1'b1;
        waitIdle("bp_idle_timeout");
        checkOutput("bp_scoreboard_empty", sb.size(), 0);

        $display("[TB] reset mid-flight");
        @(posedge clk); #1;
        out_ready = 1'b0;
        k = cyc;
        for (int s = 0; s < 3; s++) applyStimulus(32'hC0DE_0000 + 32'(s), k + 1, 0);
        repeat (5) begin @(posedge clk); #1; end
        checkOutput("preflush_busy", busy, 1);
        reset = 1'b0;
        sb.delete();
        tag_model = '0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        checkOutput("flush_out_valid", out_valid, 0);
        checkOutput("flush_busy", busy, 0);
        checkOutput("flush_credits", dut.credits, DEPTH);
        checkOutput("flush_in_ready", in_ready, 5'h1f);
        @(posedge clk); #1 out_ready = 1'b1;

        $display("[TB] streaming");
        @(posedge clk); #1;
        k = cyc;
        for (int s = 0; s < 40; s++) applyStimulus(32'h0BAD_F00D + 32'h0001_0203 * s, k + 1, 0);
        got = 1'b0;
        for (int n = 0; n < 1000 && !got; n++) begin
            @(negedge clk);
            checkOutput("stream_credits_bound", (dut.credits <= DEPTH), 1);
            if (!busy && ptr[0] == nsets) got = 1'b1;
        end
        if (!got) checkOutput("stream_idle_timeout", busy, 0);
        checkOutput("final_scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
